prog_mem_loader: RTL and testbench
==================================

PROG_MEM_LOADER -- requirements
Module: prog_mem_loader

Interface
REQ-001 Parameter NBITS_O, default 11, instruction address width.
REQ-002 Parameter NBITS_D, default 16, instruction width; SHALL be a multiple of 8 (BPW = NBITS_D/8 bytes per word).
REQ-003 Parameter CELDAS, default 1024, memory depth in words; SHALL be at most 2**NBITS_O.
REQ-004 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-005 i_reset  input  1  asynchronous, active-low reset.
REQ-006 i_load_start  input  1  single-cycle request to begin a program load.
REQ-007 i_load_end  input  1  single-cycle request to terminate a program load.
REQ-008 i_byte  input  8  loader byte, sent MSB-byte first within each word.
REQ-009 i_byte_valid  input  1  i_byte is valid.
REQ-010 o_byte_ready  output  1  block accepts i_byte this cycle.
REQ-011 i_rd_en  input  1  instruction fetch request.
REQ-012 i_Addr  input  NBITS_O  fetch address.
REQ-013 o_Data  output  NBITS_D  fetched instruction, registered.
REQ-014 o_valid  output  1  o_Data updated by a fetch in the previous cycle.
REQ-015 o_len  output  NBITS_O+1  number of loaded words.
REQ-016 o_state  output  2  IDLE=00, LOAD=01, RUN=10.
REQ-017 o_overflow  output  1  sticky: a byte was offered while memory was full.

Function
REQ-018 FSM states: IDLE, LOAD and RUN; 11 SHALL be unreachable and SHALL decode as IDLE.
REQ-019 IDLE or RUN with i_load_start=1 -> LOAD next cycle. The same edge SHALL clear the write pointer, byte counter, assembly register, o_len and o_overflow.
REQ-020 LOAD: o_byte_ready=1 unless wr_ptr==CELDAS. In all other states o_byte_ready=0.
REQ-021 A byte is accepted only when i_byte_valid and o_byte_ready are both 1. It SHALL shift into the assembly register (first byte becomes bits NBITS_D-1:NBITS_D-8), and the byte counter SHALL increment.
REQ-022 On acceptance of byte BPW of a word:
- the assembled word SHALL be written to memory[wr_ptr] on that edge;
- wr_ptr and o_len SHALL increment;
- the byte counter SHALL return to 0.
REQ-023 When wr_ptr reaches CELDAS, the FSM SHALL move to RUN on the same edge as the final write; o_len=CELDAS.
REQ-024 While full in LOAD (not reachable per REQ-023, defensive), or in RUN/IDLE, i_byte_valid=1 SHALL set o_overflow. The byte SHALL be dropped.
REQ-025 LOAD with i_load_end=1 -> RUN next cycle.
- A partial word (byte counter not 0) SHALL be discarded and not written.
- o_len SHALL equal completed words.
REQ-026 In LOAD, if i_load_end coincides with acceptance of the final byte of a word, the word SHALL be written and counted first, then the FSM SHALL move to RUN.
REQ-027 i_load_end outside LOAD SHALL be ignored. i_load_start in LOAD SHALL restart the load per REQ-019.
REQ-028 In RUN with i_rd_en=1, the edge SHALL set o_valid=1 and update o_Data:
- o_Data=memory[i_Addr] if i_Addr < o_len;
- o_Data=0 (HALT opcode) if i_Addr >= o_len.
REQ-029 Fetch latency SHALL be exactly 1 cycle.
REQ-030 With i_rd_en=0, or outside RUN, o_valid=0 and o_Data SHALL hold its last value.
REQ-031 Address compare SHALL be unsigned, zero-extended to NBITS_O+1 bits.
REQ-032 Memory writes and reads SHALL never occur on the same edge (mutually exclusive by state).

Reset
REQ-033 i_reset=0 SHALL immediately force, regardless of clock:
- state=IDLE, o_Data=0, o_valid=0, o_byte_ready=0, o_len=0, o_overflow=0;
- wr_ptr=0, byte counter=0, assembly register=0.
REQ-034 Memory array contents SHALL NOT be reset. Because o_len=0, all post-reset fetches return 0 until a new load completes.
REQ-035 Reset asserted mid-LOAD SHALL abandon the load. Reset release SHALL take effect at the first rising edge after deassertion.

Verification
REQ-036 Reset, load_start, bytes 10 01 28 02 08 07 (NBITS_D=16), load_end; fetch 0,1,2,3 -> o_Data 0x1001, 0x2802, 0x0807, 0x0000; o_len=3; o_valid one cycle after each i_rd_en.
REQ-037 Load bytes 10 01 28, then load_end -> o_len=1; fetch 1 returns 0x0000 (partial word discarded).
REQ-038 CELDAS=4: send 10 bytes -> RUN after byte 8, o_len=4, o_byte_ready=0, o_overflow=1 after byte 9.
REQ-039 Final byte of word 2 accepted on the same cycle as i_load_end -> o_len=2, word 2 readable.
REQ-040 Reset pulsed after 3 words loaded -> state IDLE, o_len=0, fetch 0 gives o_valid=0; reload with 2 words -> fetch 2 returns 0x0000.
REQ-041 Byte stream with random i_byte_valid gaps and a reload from RUN -> contents match a reference model; fetches while in LOAD give o_valid=0.

Source files
------------

// File: rtl/prog_mem_loader.sv
// Program memory loader: assembles MSB-first bytes into words, then serves 1-cycle registered fetches (HALT=0 past o_len).
// Byte backpressure: o_byte_ready only in LOAD while memory not full; offered bytes that are refused set sticky o_overflow.
module prog_mem_loader #(
    parameter int NBITS_O = 11,
    parameter int NBITS_D = 16,
    parameter int CELDAS  = 1024
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_load_start,
    input  logic               i_load_end,
    input  logic [7:0]         i_byte,
    input  logic               i_byte_valid,
    output logic               o_byte_ready,
    input  logic               i_rd_en,
    input  logic [NBITS_O-1:0] i_Addr,
    output logic [NBITS_D-1:0] o_Data,
    output logic               o_valid,
    output logic [NBITS_O:0]   o_len,
    output logic [1:0]         o_state,
    output logic               o_overflow
);

    localparam int BPW = NBITS_D / 8;
    localparam int CW  = $clog2(BPW + 1);
    localparam int AW  = (CELDAS > 1) ? $clog2(CELDAS) : 1;
    localparam int ASW = (NBITS_D > 8) ? NBITS_D - 8 : 1;

    localparam logic [CW-1:0]    CNT_LAST = CW'(BPW - 1);
    localparam logic [NBITS_O:0] PTR_LAST = (NBITS_O + 1)'(CELDAS - 1);
    localparam logic [NBITS_O:0] PTR_FULL = (NBITS_O + 1)'(CELDAS);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_LOAD = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [NBITS_O:0]   ptr_q, ptr_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [ASW-1:0]     asm_q, asm_d;
    logic               ovf_q, ovf_d;
    logic [NBITS_D-1:0] data_q, data_d;
    logic               valid_q, valid_d;

    logic [NBITS_D-1:0] mem [CELDAS];
    logic [NBITS_D-1:0] word;
    logic               mem_we;
    logic               byte_rdy;
    logic               rd_hit;

    // The word being completed is the earlier bytes (MSB side) followed by the incoming byte.
    generate
        if (NBITS_D == 8) begin : g_w8
            assign word = i_byte;
        end else begin : g_wn
            assign word = {asm_q, i_byte};
        end
    endgenerate

    assign byte_rdy = (state_q == ST_LOAD) && (ptr_q != PTR_FULL);
    assign rd_hit   = ({1'b0, i_Addr} < ptr_q);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        asm_d   = asm_q;
        ovf_d   = ovf_q;
        data_d  = data_q;
        valid_d = 1'b0;
        mem_we  = 1'b0;

        if (i_byte_valid && !byte_rdy) begin
            ovf_d = 1'b1;
        end

        if (i_load_start) begin
            state_d = ST_LOAD;
            ptr_d   = '0;
            cnt_d   = '0;
            asm_d   = '0;
            ovf_d   = 1'b0;
        end else begin
            case (state_q)
                ST_LOAD: begin
                    if (i_byte_valid && byte_rdy) begin
                        asm_d = word[ASW-1:0];
                        if (cnt_q == CNT_LAST) begin
                            mem_we = 1'b1;
                            ptr_d  = ptr_q + 1'b1;
                            cnt_d  = '0;
                            if (ptr_q == PTR_LAST) begin
                                state_d = ST_RUN;
                            end
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    // A completing byte on this edge is already written above; only a partial word is lost.
                    if (i_load_end) begin
                        state_d = ST_RUN;
                        cnt_d   = '0;
                        asm_d   = '0;
                    end
                end
                ST_RUN: begin
                    if (i_rd_en) begin
                        valid_d = 1'b1;
                        data_d  = rd_hit ? mem[i_Addr[AW-1:0]] : '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            asm_q   <= '0;
            ovf_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            asm_q   <= asm_d;
            ovf_q   <= ovf_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    // Storage keeps its contents across reset; o_len=0 masks stale words.
    always_ff @(posedge i_clk) begin
        if (mem_we) begin
            mem[ptr_q[AW-1:0]] <= word;
        end
    end

    assign o_byte_ready = byte_rdy;
    assign o_Data       = data_q;
    assign o_valid      = valid_q;
    assign o_len        = ptr_q;
    assign o_overflow   = ovf_q;
    assign o_state      = ((state_q == ST_LOAD) || (state_q == ST_RUN)) ? state_q : ST_IDLE;

endmodule

// File: tb/tb_prog_mem_loader.sv
// Bench for prog_mem_loader: directed scenarios plus random traffic against a queue-based word model.
module tb_prog_mem_loader;

    localparam int NO  = 4;
    localparam int ND  = 16;
    localparam int CD  = 4;
    localparam int BPW = ND / 8;

    logic          i_clk = 1'b0;
    logic          i_reset = 1'b0;
    logic          i_load_start = 1'b0;
    logic          i_load_end = 1'b0;
    logic [7:0]    i_byte = '0;
    logic          i_byte_valid = 1'b0;
    logic          o_byte_ready;
    logic          i_rd_en = 1'b0;
    logic [NO-1:0] i_Addr = '0;
    logic [ND-1:0] o_Data;
    logic          o_valid;
    logic [NO:0]   o_len;
    logic [1:0]    o_state;
    logic          o_overflow;

    prog_mem_loader #(.NBITS_O(NO), .NBITS_D(ND), .CELDAS(CD)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_load_start (i_load_start),
        .i_load_end   (i_load_end),
        .i_byte       (i_byte),
        .i_byte_valid (i_byte_valid),
        .o_byte_ready (o_byte_ready),
        .i_rd_en      (i_rd_en),
        .i_Addr       (i_Addr),
        .o_Data       (o_Data),
        .o_valid      (o_valid),
        .o_len        (o_len),
        .o_state      (o_state),
        .o_overflow   (o_overflow)
    );

    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad = 0;

    // Reference model: 0=IDLE 1=LOAD 2=RUN, words as a plain array, pending bytes as a queue.
    int            m_state;
    int            m_len;
    bit            m_ovf;
    bit            m_valid;
    logic [ND-1:0] m_data;
    logic [ND-1:0] m_mem [CD];
    logic [7:0]    m_part [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_len   = 0;
        m_ovf   = 1'b0;
        m_valid = 1'b0;
        m_data  = '0;
        m_part.delete();
    endtask

    task automatic model_step(input bit st, input bit en, input bit bv, input logic [7:0] b,
                              input bit rd, input logic [NO-1:0] a);
        bit            rdy;
        logic [ND-1:0] w;
        rdy = (m_state == 1) && (m_len != CD);
        m_valid = 1'b0;
        if (bv && !rdy) m_ovf = 1'b1;
        if (st) begin
            m_state = 1;
            m_len   = 0;
            m_ovf   = 1'b0;
            m_part.delete();
        end else if (m_state == 1) begin
            if (bv && rdy) begin
                m_part.push_back(b);
                if (m_part.size() == BPW) begin
                    w = '0;
                    foreach (m_part[k]) w = {w[ND-9:0], m_part[k]};
                    m_mem[m_len] = w;
                    m_len++;
                    m_part.delete();
                    if (m_len == CD) m_state = 2;
                end
            end
            if (en) begin
                m_state = 2;
                m_part.delete();
            end
        end else if (m_state == 2 && rd) begin
            m_valid = 1'b1;
            m_data  = (int'(a) < m_len) ? m_mem[a] : '0;
        end
    endtask

    task automatic check_all(input string tag);
        check_eq({tag, ".state"}, 32'(o_state), 32'(m_state));
        check_eq({tag, ".len"}, 32'(o_len), 32'(m_len));
        check_eq({tag, ".ovf"}, 32'(o_overflow), 32'(m_ovf));
        check_eq({tag, ".rdy"}, 32'(o_byte_ready), 32'((m_state == 1) && (m_len != CD)));
        check_eq({tag, ".vld"}, 32'(o_valid), 32'(m_valid));
        check_eq({tag, ".dat"}, 32'(o_Data), 32'(m_data));
    endtask

    task automatic cycle(input string tag, input bit st, input bit en, input bit bv,
                         input logic [7:0] b, input bit rd, input logic [NO-1:0] a);
        i_load_start = st;
        i_load_end   = en;
        i_byte_valid = bv;
        i_byte       = b;
        i_rd_en      = rd;
        i_Addr       = a;
        model_step(st, en, bv, b, rd, a);
        @(posedge i_clk);
        #1;
        i_load_start = 1'b0;
        i_load_end   = 1'b0;
        i_byte_valid = 1'b0;
        i_rd_en      = 1'b0;
        check_all(tag);
    endtask

    task automatic start_load(input string tag);
        cycle(tag, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, '0);
    endtask

    task automatic send(input string tag, input logic [7:0] b);
        cycle(tag, 1'b0, 1'b0, 1'b1, b, 1'b0, '0);
    endtask

    task automatic end_load(input string tag);
        cycle(tag, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, '0);
    endtask

    task automatic fetch(input string tag, input logic [NO-1:0] a);
        cycle(tag, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, a);
    endtask

    task automatic idle(input string tag);
        cycle(tag, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, '0);
    endtask

    // Asserted and released between edges so the asynchronous clear is observed without a clock.
    task automatic do_reset(input string tag);
        #2;
        i_reset = 1'b0;
        model_reset();
        #1;
        check_all(tag);
        #2;
        i_reset = 1'b1;
    endtask

    initial begin
        logic [7:0] seq36 [6];
        seq36 = '{8'h10, 8'h01, 8'h28, 8'h02, 8'h08, 8'h07};
        for (int k = 0; k < CD; k++) m_mem[k] = '0;

        model_reset();
        #12;
        check_all("reset");
        i_reset = 1'b1;
        idle("post_reset");

        // Basic load of three words and fetch past the end.
        start_load("b.start");
        foreach (seq36[k]) send("b.byte", seq36[k]);
        end_load("b.end");
        check_eq("b.len3", 32'(o_len), 32'd3);
        fetch("b.f0", 4'd0);
        check_eq("b.f0_const", 32'(o_Data), 32'h1001);
        idle("b.hold");
        check_eq("b.hold_vld", 32'(o_valid), 32'd0);
        fetch("b.f1", 4'd1);
        check_eq("b.f1_const", 32'(o_Data), 32'h2802);
        fetch("b.f2", 4'd2);
        check_eq("b.f2_const", 32'(o_Data), 32'h0807);
        fetch("b.f3", 4'd3);
        check_eq("b.f3_const", 32'(o_Data), 32'h0000);
        check_eq("b.f3_vld", 32'(o_valid), 32'd1);

        // Partial word discarded on load_end.
        start_load("p.start");
        send("p.b0", 8'h10);
        send("p.b1", 8'h01);
        send("p.b2", 8'h28);
        end_load("p.end");
        check_eq("p.len1", 32'(o_len), 32'd1);
        fetch("p.f1", 4'd1);
        check_eq("p.f1_halt", 32'(o_Data), 32'h0000);

        // Fill to capacity, then overflow.
        start_load("o.start");
        for (int k = 0; k < 10; k++) begin
            send("o.byte", 8'hA0 + 8'(k));
            if (k == 7) begin
                check_eq("o.run_after8", 32'(o_state), 32'd2);
                check_eq("o.len_full", 32'(o_len), 32'(CD));
                check_eq("o.rdy_full", 32'(o_byte_ready), 32'd0);
                check_eq("o.ovf_clear", 32'(o_overflow), 32'd0);
            end
            if (k == 8) check_eq("o.ovf_after9", 32'(o_overflow), 32'd1);
        end
        fetch("o.f3", 4'd3);
        check_eq("o.f3_const", 32'(o_Data), 32'hA6A7);
        fetch("o.f9", 4'd9);
        check_eq("o.f9_halt", 32'(o_Data), 32'h0000);

        // Final byte of word 2 coincides with load_end.
        start_load("e.start");
        send("e.b0", 8'h11);
        send("e.b1", 8'h22);
        send("e.b2", 8'h33);
        cycle("e.b3_end", 1'b0, 1'b1, 1'b1, 8'h44, 1'b0, '0);
        check_eq("e.len2", 32'(o_len), 32'd2);
        check_eq("e.run", 32'(o_state), 32'd2);
        fetch("e.f1", 4'd1);
        check_eq("e.f1_const", 32'(o_Data), 32'h3344);

        // Reset in the middle of a load, then a shorter reload.
        start_load("r.start");
        for (int k = 0; k < 6; k++) send("r.byte", 8'h50 + 8'(k));
        do_reset("r.async");
        check_eq("r.idle", 32'(o_state), 32'd0);
        check_eq("r.len0", 32'(o_len), 32'd0);
        fetch("r.f0_idle", 4'd0);
        check_eq("r.f0_novld", 32'(o_valid), 32'd0);
        start_load("r2.start");
        for (int k = 0; k < 4; k++) send("r2.byte", 8'h60 + 8'(k));
        end_load("r2.end");
        fetch("r2.f2", 4'd2);
        check_eq("r2.f2_halt", 32'(o_Data), 32'h0000);
        fetch("r2.f1", 4'd1);
        check_eq("r2.f1_const", 32'(o_Data), 32'h6263);

        // Random traffic: gappy bytes, reloads from RUN, fetches in all states, rare resets.
        for (int n = 0; n < 1500; n++) begin
            bit            st, en, bv, rd;
            logic [7:0]    b;
            logic [NO-1:0] a;
            st = ($urandom_range(0, 39) == 0);
            en = ($urandom_range(0, 19) == 0);
            bv = ($urandom_range(0, 9) < 6);
            rd = ($urandom_range(0, 1) == 1);
            b  = 8'($urandom);
            a  = NO'($urandom_range(0, 15));
            cycle("rnd", st, en, bv, b, rd, a);
            if ($urandom_range(0, 299) == 0) do_reset("rnd.rst");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
